// File: rtl/adc_serial_reader_pkg.sv
// Shared definitions for the serial temperature ADC reader and its consumers.
// ADC_W sizes adc_data on both the producer and the temperature calculator side.
package adc_serial_reader_pkg;
    localparam int ADC_W             = 16;
    localparam int CLK_DIV_DEF       = 4;
    localparam int SAMPLE_PERIOD_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GUARD = 3'd4
    } state_t;
endpackage

// File: rtl/adc_serial_reader_sclk_gen.sv
// Half-period timer for the ADC serial clock: one phase_end every CLK_DIV cycles while enabled.
// rise_stb/fall_stb mark the half-periods in which SCLK toggles.
module adc_serial_reader_sclk_gen
    import adc_serial_reader_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_toggle,
    output logic o_phase_end,
    output logic o_rise_stb,
    output logic o_fall_stb
);
    localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= LOAD;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= LOAD;
            r_phase <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt <= LOAD;
            if (i_toggle) begin
                r_phase <= ~r_phase;
            end
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_phase_end = i_en && (r_cnt == '0);
    assign o_rise_stb  = o_phase_end && i_toggle && !r_phase;
    assign o_fall_stb  = o_phase_end && i_toggle && r_phase;
endmodule

// File: rtl/adc_serial_reader.sv
// SPI mode-0 master reading one DATA_W-bit sample, MSB first, from the serial temperature ADC.
// Triggered by a start pulse or by the internal periodic sampler when auto mode is on.
module adc_serial_reader
    import adc_serial_reader_pkg::*;
#(
    parameter int DATA_W        = ADC_W,
    parameter int CLK_DIV       = CLK_DIV_DEF,
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_auto_en,
    input  logic              i_adc_miso,
    output logic              o_adc_cs_n,
    output logic              o_adc_sclk,
    output logic [DATA_W-1:0] o_adc_data,
    output logic              o_adc_valid,
    output logic              o_busy,
    output logic              o_overrun
);
    // state | meaning
    // IDLE  | waiting for start or auto tick
    // SETUP | CS low, SCLK low for one half-period
    // SHIFT | DATA_W SCLK periods, MISO sampled on each rising edge
    // HOLD  | SCLK low for one half-period before CS release
    // GUARD | minimum CS-high time, still busy

    localparam int BW = $clog2(DATA_W + 1);
    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [PW-1:0]     r_per_cnt;
    logic              w_auto_tick;
    logic              w_trigger;
    logic              w_accept;
    logic              w_capture;
    logic              w_release;
    logic              w_phase_end;
    logic              w_rise_stb;
    logic              w_fall_stb;

    assign w_auto_tick = i_auto_en && (r_per_cnt == PW'(SAMPLE_PERIOD - 1));
    assign w_trigger   = i_start || w_auto_tick;

    adc_serial_reader_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (r_state != ST_IDLE),
        .i_toggle   (r_state == ST_SHIFT),
        .o_phase_end(w_phase_end),
        .o_rise_stb (w_rise_stb),
        .o_fall_stb (w_fall_stb)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = ST_SETUP;
                    w_accept    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_phase_end) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_fall_stb && (r_bit_cnt == BW'(1))) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_GUARD;
                    w_capture   = 1'b1;
                end
            end
            ST_GUARD: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_adc_cs_n  <= 1'b1;
            o_adc_sclk  <= 1'b0;
            o_adc_data  <= '0;
            o_adc_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
            r_per_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
        end else begin
            o_adc_valid <= 1'b0;
            if (w_accept) begin
                o_adc_cs_n <= 1'b0;
                o_busy     <= 1'b1;
                r_bit_cnt  <= BW'(DATA_W);
            end
            if (w_rise_stb) begin
                o_adc_sclk <= 1'b1;
                r_shift    <= DATA_W'({r_shift, i_adc_miso});
            end
            if (w_fall_stb) begin
                o_adc_sclk <= 1'b0;
                r_bit_cnt  <= r_bit_cnt - BW'(1);
            end
            if (w_capture) begin
                o_adc_cs_n  <= 1'b1;
                o_adc_data  <= r_shift;
                o_adc_valid <= 1'b1;
            end
            if (w_release) begin
                o_busy <= 1'b0;
            end
            // a tick that finds the reader busy is dropped, only the flag remembers it
            if (!i_auto_en) begin
                r_per_cnt <= '0;
                o_overrun <= 1'b0;
            end else begin
                r_per_cnt <= w_auto_tick ? '0 : r_per_cnt + PW'(1);
                if (w_auto_tick && o_busy) o_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: two instances (sample period 1000 and 140) checked every cycle
// against a frame-timing model, plus directed literal checks.
module tb_adc_serial_reader;
    localparam int W     = 16;
    localparam int D     = 4;
    localparam int P0    = 1000;
    localparam int P1    = 140;
    localparam int VLAT  = D * (2 * W + 2);
    localparam int FRAME = D * (2 * W + 3);

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   start;
    logic [1:0]   auto_en;
    logic [1:0]   miso;
    logic [1:0]   cs_n;
    logic [1:0]   sclk;
    logic [1:0]   valid;
    logic [1:0]   busy;
    logic [1:0]   ovr;
    logic [W-1:0] data [2];
    logic [W-1:0] word [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rises0   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge sclk[0]) rises0++;

    adc_serial_reader #(.DATA_W(W), .CLK_DIV(D), .SAMPLE_PERIOD(P0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_auto_en(auto_en[0]),
        .i_adc_miso(miso[0]), .o_adc_cs_n(cs_n[0]), .o_adc_sclk(sclk[0]),
        .o_adc_data(data[0]), .o_adc_valid(valid[0]), .o_busy(busy[0]), .o_overrun(ovr[0]));

    adc_serial_reader #(.DATA_W(W), .CLK_DIV(D), .SAMPLE_PERIOD(P1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_auto_en(auto_en[1]),
        .i_adc_miso(miso[1]), .o_adc_cs_n(cs_n[1]), .o_adc_sclk(sclk[1]),
        .o_adc_data(data[1]), .o_adc_valid(valid[1]), .o_busy(busy[1]), .o_overrun(ovr[1]));

    // ADC: first bit valid when CS falls, next bit after every SCLK falling edge
    for (genvar g = 0; g < 2; g++) begin : g_adc
        logic [W-1:0] sh;
        logic         bit_o = 1'b0;
        bit           fresh = 1'b1;
        always @(cs_n[g] or negedge sclk[g]) begin
            if (cs_n[g] !== 1'b0) begin
                fresh = 1'b1;
            end else begin
                if (fresh) sh = word[g];
                else       sh = {sh[W-2:0], 1'b0};
                fresh = 1'b0;
                bit_o = sh[W-1];
            end
        end
        assign miso[g] = bit_o;
    end

    // Frame model: t = cycles since the accepting edge, -1 when idle
    int           t [2]      = '{-1, -1};
    int           pc [2]     = '{0, 0};
    bit           m_ovr [2]  = '{1'b0, 1'b0};
    bit           m_valid[2] = '{1'b0, 1'b0};
    logic [W-1:0] m_data [2] = '{16'h0, 16'h0};
    logic [W-1:0] m_cur [2]  = '{16'h0, 16'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            int lim;
            bit tk;
            bit wb;
            if (!rst_n) begin
                t[i] = -1; pc[i] = 0; m_ovr[i] = 1'b0; m_valid[i] = 1'b0; m_data[i] = '0;
            end else begin
                lim = (i == 0) ? P0 : P1;
                tk  = auto_en[i] && (pc[i] == lim - 1);
                wb  = (t[i] >= 0);
                if (!auto_en[i])  m_ovr[i] = 1'b0;
                else if (tk && wb) m_ovr[i] = 1'b1;
                pc[i] = (!auto_en[i] || tk) ? 0 : pc[i] + 1;
                m_valid[i] = 1'b0;
                if (wb) begin
                    t[i]++;
                    if (t[i] == VLAT) begin
                        m_data[i]  = m_cur[i];
                        m_valid[i] = 1'b1;
                    end
                    if (t[i] == FRAME) t[i] = -1;
                end else if (start[i] || tk) begin
                    t[i]     = 0;
                    m_cur[i] = word[i];
                end
            end
        end
    end

    function automatic bit f_sclk(input int n);
        return (n >= 2 * D) && (n < 2 * D * (W + 1)) && (((n - 2 * D) % (2 * D)) < D);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                logic [W+4:0] e;
                logic [W+4:0] a;
                e = {!(t[i] >= 0 && t[i] < VLAT), f_sclk(t[i]), m_valid[i], (t[i] >= 0),
                     m_ovr[i], m_data[i]};
                a = {cs_n[i], sclk[i], valid[i], busy[i], ovr[i], data[i]};
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL model[%0d] cyc=%0d t=%0d {cs_n,sclk,valid,busy,ovr,data} got %h expected %h",
                             i, cyc, t[i], a, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // what: 0 = valid pulse, 1 = busy low, 2 = busy high
    task automatic wait_for(input int i, input int what, input int lim, input string nm);
        bit hit = 1'b0;
        for (int k = 0; k < lim && !hit; k++) begin
            @(negedge clk);
            case (what)
                0:       hit = (valid[i] === 1'b1);
                1:       hit = (busy[i] === 1'b0);
                default: hit = (busy[i] === 1'b1);
            endcase
        end
        if (!hit) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout_%s: no event within %0d cycles", nm, lim);
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;
        int r0;
        start   = 2'b00;
        auto_en = 2'b00;
        word[0] = '0;
        word[1] = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cs_n", cs_n[0], 1);
        chk("reset_data", data[0], 0);
        chk("reset_busy", busy[0], 0);

        // single frame, 16'hA5C3
        word[0] = 16'hA5C3;
        r0 = rises0;
        pulse_start(0);
        c0 = cyc;
        chk("accept_busy", busy[0], 1);
        wait_for(0, 0, 200, "valid_a5c3");
        chk("latency", cyc - c0, 136);
        chk("data_a5c3", data[0], 16'hA5C3);
        chk("sclk_rises", rises0 - r0, 16);
        @(negedge clk);
        chk("valid_width", valid[0], 0);
        wait_for(0, 1, 20, "idle_a5c3");

        // back-to-back 0000 then FFFF
        word[0] = 16'h0000;
        pulse_start(0);
        wait_for(0, 0, 200, "valid_0000");
        c1 = cyc;
        chk("data_0000", data[0], 16'h0000);
        wait_for(0, 1, 20, "idle_0000");
        word[0] = 16'hFFFF;
        pulse_start(0);
        chk("cs_high_min", ((cyc - c1) >= 4) ? 1 : 0, 1);
        wait_for(0, 0, 200, "valid_ffff");
        chk("data_ffff", data[0], 16'hFFFF);
        wait_for(0, 1, 20, "idle_ffff");

        // async reset while SCLK is high in SHIFT
        word[0] = 16'h1234;
        pulse_start(0);
        repeat (50) @(negedge clk);
        chk("pre_reset_sclk", sclk[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cs_n", cs_n[0], 1);
        chk("async_sclk", sclk[0], 0);
        chk("async_data", data[0], 0);
        chk("async_valid", valid[0], 0);
        chk("async_busy", busy[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("quiet_after_reset", busy[0], 0);

        // auto mode, period 1000
        word[0] = 16'h3C5A;
        auto_en[0] = 1'b1;
        wait_for(0, 0, 1200, "auto_v1");
        c0 = cyc;
        wait_for(0, 0, 1200, "auto_v2");
        chk("auto_spacing1", cyc - c0, 1000);
        c0 = cyc;
        wait_for(0, 0, 1200, "auto_v3");
        chk("auto_spacing2", cyc - c0, 1000);
        chk("auto_data", data[0], 16'h3C5A);
        chk("auto_no_overrun", ovr[0], 0);
        auto_en[0] = 1'b0;
        wait_for(0, 1, 200, "auto_idle");

        // period 140: start two cycles before the tick, tick must be dropped
        word[1] = 16'h5AA5;
        auto_en[1] = 1'b1;
        repeat (137) @(negedge clk);
        pulse_start(1);
        repeat (2) @(negedge clk);
        chk("overrun_set", ovr[1], 1);
        wait_for(1, 0, 200, "valid_5aa5");
        chk("overrun_data", data[1], 16'h5AA5);
        auto_en[1] = 1'b0;
        @(negedge clk);
        chk("overrun_clear", ovr[1], 0);
        wait_for(1, 1, 200, "idle_p140");

        // start held high: frames back to back, never restarted mid-frame
        word[0] = 16'h0F0F;
        start[0] = 1'b1;
        wait_for(0, 0, 200, "held_v1");
        c0 = cyc;
        wait_for(0, 0, 200, "held_v2");
        chk("held_spacing", cyc - c0, 141);
        chk("held_data", data[0], 16'h0F0F);
        start[0] = 1'b0;
        wait_for(0, 1, 200, "held_idle");
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
